mpsoc_dbg_syncreg_arb: RTL and testbench
========================================

# mpsoc_dbg_syncreg_arb

CLKA-domain scheduler that shares one `mpsoc_dbg_syncreg` 4-bit clock-crossing channel among four status requesters. Each requester presents a 2-bit status. The block detects per-requester changes against a shadow copy and picks one changed requester at a time. It drives the nibble {id, status} onto the syncreg `DATA_IN` and holds it long enough for the syncreg toggle handshake to complete before moving on. It sits between the debug-unit status sources (stall, breakpoint, error flags) and the syncreg instance feeding the JTAG/CLKB side.

## Interface
- `HOLD_CYCLES`, default 8: CLKA cycles each nibble is held on `SYNC_DATA`. Legal range is 2..255. Must cover the worst-case syncreg strobe/ack round trip.
- `CLKA` input 1: source-domain clock; all logic is on its rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `EN` input 1: when low, no new transfer starts; a transfer in progress completes.
- `REQ_STATUS` input 8: four 2-bit status fields; requester i is bits [2i+1:2i].
- `SYNC_DATA` output 4: to syncreg `DATA_IN`; encoding {id[1:0], status[1:0]}.
- `SENT` output 4: one-cycle pulse per requester when its transfer completes.
- `BUSY` output 1: high while in HOLD.

## Operation
- Shadow registers: `shadow[i]` (2 bits) holds the last value transferred for requester i.
- Dirty: `dirty[i] = (REQ_STATUS[i] != shadow[i])`, combinational.
- Arbitration is round-robin over dirty requesters, starting at pointer `rr` (2 bits). After a transfer from id k completes, `rr <= k+1` (mod 4).
- States:
  - IDLE: if `EN & |dirty`, select winner w:
    - `SYNC_DATA <= {w, REQ_STATUS[w]}`
    - `sent_val <= REQ_STATUS[w]`
    - `cur_id <= w`
    - `cnt <= HOLD_CYCLES-1`
    - go to HOLD
    - Otherwise stay in IDLE; `SYNC_DATA` is unchanged.
  - HOLD: `cnt` decrements each cycle. When `cnt == 0`:
    - `shadow[cur_id] <= sent_val`
    - `SENT[cur_id]` pulses
    - update `rr`
    - go to IDLE
- Changes to the selected requester during HOLD do not alter `SYNC_DATA`. On completion the shadow takes `sent_val`, not the live input. If the live value differs, the requester is dirty again and is re-sent on a later turn. A value that reverts to the old shadow during HOLD is therefore still re-sent, so the far side always converges to the live value.
- Every issued nibble differs from the previous `SYNC_DATA`, which guarantees the syncreg sees a change:
  - A different id gives a different nibble.
  - The same id requires `REQ_STATUS != shadow`, and the shadow equals the last sent status for that id.
- `EN` low during HOLD has no effect until the return to IDLE.

## Timing
- Reset values:
  - `SYNC_DATA = 4'b0000`, which matches the syncreg reset output of id 0 / status 0.
  - All shadows 0; `rr = 0`; state IDLE.
  - `SENT = 0`; `BUSY = 0`.
- Latency: with `REQ_STATUS` changed before edge t and the block idle, `SYNC_DATA` updates at edge t and `BUSY` rises at t.
- `SENT` pulses at edge t+`HOLD_CYCLES`; `BUSY` falls at the same edge.
- Next issue is at the earliest at edge t+`HOLD_CYCLES`+1, which gives one IDLE cycle between transfers.
- Throughput: one nibble per `HOLD_CYCLES`+1 cycles.
- `RST` mid-HOLD:
  - Immediate return to the reset values above.
  - Any transfer in progress is abandoned.
  - All requesters with nonzero status become dirty and are re-sent after reset.

## Configuration
- Macro: `MPSOC_DBG_SYNCREG_ARB_PRIO0_EN`.
- When defined, requester 0 has strict priority: if `dirty[0]`, it wins regardless of `rr`. Requesters 1..3 round-robin among themselves, and `rr` does not advance on requester-0 transfers.
- When undefined, all four requesters share a single round-robin.

## Structure
- Shared package `mpsoc_dbg_pkg` holds:
  - `NREQ = 4` and `ID_W = 2`
  - the state enum `{ARB_IDLE, ARB_HOLD}`
  - the nibble struct `{id, status}`
- One sub-module is natural: `mpsoc_dbg_rr_pick`, a combinational 4-way round-robin picker (inputs `dirty`, `rr`; outputs `valid`, `winner`). The priority-0 variant lives in the parent.

## Test plan
- Reset: set `REQ_STATUS=8'h00` and release `RST`. Expect `SYNC_DATA=0`, `BUSY=0`, and no `SENT` pulses for 50 cycles.
- Single change with `HOLD_CYCLES=8`: set requester 2 status to 2'b11. Expect `SYNC_DATA=4'b1011` on the next edge, then `SENT=4'b0100` exactly 8 edges later, then return to IDLE.
- Simultaneous changes: set all four to 2'b01 at once with `rr=0`. Expect issue order 0,1,2,3 (nibbles 1,5,9,D), spaced 9 cycles apart. With `MPSOC_DBG_SYNCREG_ARB_PRIO0_EN` defined, re-dirtying requester 0 mid-sequence makes it issue next.
- Change during HOLD: requester 1 goes 01→10 mid-HOLD of its 01 transfer. Expect `SENT[1]`, then a second transfer with `SYNC_DATA=4'b0110`. Reverting to 00 instead also forces a re-send of 00.
- `EN` gating: hold `EN=0` with requester 3 dirty; expect no issue. When `EN` rises, expect `SYNC_DATA=4'b11xx` on the next edge. Dropping `EN` mid-HOLD still produces the `SENT` pulse.
- Reset mid-HOLD: assert `RST` 3 cycles into a HOLD. Expect `SYNC_DATA=0` and `BUSY=0` asynchronously. After release, the nonzero requester is re-sent.

Source files
------------

// File: rtl/mpsoc_dbg_syncreg_arb_pkg.sv
// Shared types and constants for the debug-status syncreg scheduler.
// Holds the requester count, id width, arbiter state encoding and the
// {id, status} nibble layout driven into the syncreg DATA_IN.
package mpsoc_dbg_pkg;

  localparam int NREQ  = 4;
  localparam int ID_W  = 2;
  localparam int ST_W  = 2;
  localparam int NIB_W = ID_W + ST_W;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [ST_W-1:0] status;
  } arb_nibble_t;

  function automatic arb_nibble_t make_nibble(input logic [ID_W-1:0] id,
                                              input logic [ST_W-1:0] status);
    arb_nibble_t n;
    n.id     = id;
    n.status = status;
    return n;
  endfunction

endpackage

// File: rtl/mpsoc_dbg_syncreg_arb_if.sv
// Status/handshake bundle between the debug status sources, the scheduler
// and the syncreg DATA_IN. master = source/observer side, slave = scheduler.
interface mpsoc_dbg_syncreg_arb_if;

  logic                                              EN;
  logic [mpsoc_dbg_pkg::NREQ*mpsoc_dbg_pkg::ST_W-1:0] REQ_STATUS;
  logic [mpsoc_dbg_pkg::NIB_W-1:0]                   SYNC_DATA;
  logic [mpsoc_dbg_pkg::NREQ-1:0]                    SENT;
  logic                                              BUSY;

  modport master (
    output EN,
    output REQ_STATUS,
    input  SYNC_DATA,
    input  SENT,
    input  BUSY
  );

  modport slave (
    input  EN,
    input  REQ_STATUS,
    output SYNC_DATA,
    output SENT,
    output BUSY
  );

endinterface

// File: rtl/mpsoc_dbg_syncreg_arb_rr_pick.sv
// mpsoc_dbg_rr_pick: combinational 4-way round-robin picker.
// Scans requesters starting at i_rr and returns the first dirty one.
module mpsoc_dbg_rr_pick
  import mpsoc_dbg_pkg::*;
(
  input  logic [NREQ-1:0] i_dirty,
  input  logic [ID_W-1:0] i_rr,
  output logic            o_valid,
  output logic [ID_W-1:0] o_winner
);

  logic [ID_W-1:0] w_idx;

  // Walk from the farthest offset back to i_rr so the nearest dirty one wins.
  always_comb begin
    o_valid  = 1'b0;
    o_winner = i_rr;
    w_idx    = i_rr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = i_rr + ID_W'(k);
      if (i_dirty[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
  end

endmodule

// File: rtl/mpsoc_dbg_syncreg_arb.sv
// mpsoc_dbg_syncreg_arb: shares one 4-bit syncreg channel among four 2-bit
// status requesters. A requester whose live status differs from its shadow
// is dirty; one dirty requester at a time is picked, its {id, status} nibble
// is held on SYNC_DATA for HOLD_CYCLES cycles, then the shadow is updated.
// Optional build macro: MPSOC_DBG_SYNCREG_ARB_PRIO0_EN gives requester 0
// strict priority, the others round-robin among themselves.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ARB_IDLE | waiting for EN and a dirty requester; SYNC_DATA held
// ARB_HOLD | nibble on SYNC_DATA, hold down-counter running to zero
module mpsoc_dbg_syncreg_arb
  import mpsoc_dbg_pkg::*;
#(
  parameter int HOLD_CYCLES = 8
)
(
  input  logic                     CLKA,
  input  logic                     RST,
  mpsoc_dbg_syncreg_arb_if.slave   bus
);

  localparam logic [0:0] S_IDLE    = ARB_IDLE;
  localparam logic [0:0] S_HOLD    = ARB_HOLD;
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 2 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 2..255");
  end

  logic [0:0]           r_state;
  logic [7:0]           r_cnt;
  logic [ID_W-1:0]      r_rr;
  logic [ID_W-1:0]      r_cur_id;
  logic [ST_W-1:0]      r_sent_val;
  logic [NREQ*ST_W-1:0] r_shadow;
  logic [NIB_W-1:0]     r_sync_data;
  logic [NREQ-1:0]      r_sent;

  logic [NREQ-1:0]      w_dirty;
  logic [NREQ-1:0]      w_pick_dirty;
  logic                 w_pick_valid;
  logic [ID_W-1:0]      w_pick_winner;
  logic                 w_valid;
  logic [ID_W-1:0]      w_winner;
  logic [ST_W-1:0]      w_win_status;
  logic                 w_hold_done;

  // A requester is dirty while its live status differs from what was last sent.
  always_comb begin
    w_dirty = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_dirty[i] = (bus.REQ_STATUS[i*ST_W +: ST_W] != r_shadow[i*ST_W +: ST_W]);
    end
  end

`ifdef MPSOC_DBG_SYNCREG_ARB_PRIO0_EN
  // Requester 0 is taken out of the ring; it pre-empts whatever the ring picks.
  assign w_pick_dirty = w_dirty & {{(NREQ-1){1'b1}}, 1'b0};
`else
  assign w_pick_dirty = w_dirty;
`endif

  mpsoc_dbg_rr_pick u_rr_pick (
    .i_dirty  (w_pick_dirty),
    .i_rr     (r_rr),
    .o_valid  (w_pick_valid),
    .o_winner (w_pick_winner)
  );

`ifdef MPSOC_DBG_SYNCREG_ARB_PRIO0_EN
  // Strict priority for requester 0 ahead of the ring result.
  always_comb begin
    w_valid  = w_pick_valid;
    w_winner = w_pick_winner;
    if (w_dirty[0]) begin
      w_valid  = 1'b1;
      w_winner = '0;
    end
  end
`else
  // Plain ring over all requesters.
  always_comb begin
    w_valid  = w_pick_valid;
    w_winner = w_pick_winner;
  end
`endif

  assign w_win_status = bus.REQ_STATUS[{w_winner, 1'b0} +: ST_W];
  assign w_hold_done  = (r_cnt == '0);

  // Arbiter FSM: issue a nibble from IDLE, count down the hold, retire in HOLD.
  always_ff @(posedge CLKA or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rr        <= '0;
      r_cur_id    <= '0;
      r_sent_val  <= '0;
      r_shadow    <= '0;
      r_sync_data <= '0;
      r_sent      <= '0;
    end else begin
      r_sent <= '0;
      if (r_state == S_IDLE) begin
        if (bus.EN && w_valid) begin
          r_sync_data <= make_nibble(w_winner, w_win_status);
          r_sent_val  <= w_win_status;
          r_cur_id    <= w_winner;
          r_cnt       <= HOLD_LOAD;
          r_state     <= S_HOLD;
        end
      end else begin
        if (w_hold_done) begin
          // Shadow takes what was actually sent, so a mid-hold change stays dirty.
          r_shadow[{r_cur_id, 1'b0} +: ST_W] <= r_sent_val;
          r_sent[r_cur_id]                   <= 1'b1;
`ifdef MPSOC_DBG_SYNCREG_ARB_PRIO0_EN
          if (r_cur_id != '0) begin
            r_rr <= r_cur_id + ID_W'(1);
          end
`else
          r_rr <= r_cur_id + ID_W'(1);
`endif
          r_state <= S_IDLE;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
      end
    end
  end

  assign bus.SYNC_DATA = r_sync_data;
  assign bus.SENT      = r_sent;
  assign bus.BUSY      = (r_state == S_HOLD);

endmodule

// File: tb/tb_mpsoc_dbg_syncreg_arb.sv
// Scoreboard bench for mpsoc_dbg_syncreg_arb with HOLD_CYCLES = 8.
// Stimulus pushes expected issue/SENT events; a negedge monitor pops and
// compares whenever the DUT starts a transfer or pulses SENT.
module tb_mpsoc_dbg_syncreg_arb;

  localparam int HOLD = 8;

  logic CLKA = 1'b0;
  logic RST;

  mpsoc_dbg_syncreg_arb_if bus_if ();

  mpsoc_dbg_syncreg_arb #(.HOLD_CYCLES(HOLD)) dut (
    .CLKA (CLKA),
    .RST  (RST),
    .bus  (bus_if)
  );

  always #5 CLKA = ~CLKA;

  typedef struct {
    bit         is_sent;
    logic [3:0] val;
    int         at;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_issue_cyc = 0;
  int   last_sent_cyc = 0;
  logic prev_busy = 1'b0;
  logic [3:0] held_val = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_issue(input logic [3:0] val, input int at, input int gap);
    exp_t e;
    e.is_sent = 1'b0; e.val = val; e.at = at; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_sent(input logic [3:0] val);
    exp_t e;
    e.is_sent = 1'b1; e.val = val; e.at = -1; e.gap = -1;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLKA);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    bus_if.REQ_STATUS = 8'h00;
    tick(2);
    RST = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || bus_if.BUSY) && i < budget) begin
      @(posedge CLKA);
      i++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    tick(1);
  endtask

  // Monitor: detect transfer start (BUSY rise) and completion (SENT pulse).
  always @(negedge CLKA) begin
    exp_t e;
    cyc++;
    if (RST) begin
      prev_busy = 1'b0;
    end else begin
      if (bus_if.BUSY && prev_busy)
        check("sync_stable", bus_if.SYNC_DATA, held_val);
      if (bus_if.BUSY && !prev_busy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue: got SYNC_DATA %0h required no transfer (cycle %0d)",
                   bus_if.SYNC_DATA, cyc);
        end else begin
          e = exp_q.pop_front();
          check("issue_kind", e.is_sent, 1'b0);
          check("issue_data", bus_if.SYNC_DATA, e.val);
          if (e.at >= 0)  check("issue_latency", cyc, e.at);
          if (e.gap >= 0) check("issue_gap", cyc - last_sent_cyc, e.gap);
        end
        last_issue_cyc = cyc;
        held_val = bus_if.SYNC_DATA;
      end
      if (bus_if.SENT != 4'h0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sent: got SENT %0h required none (cycle %0d)",
                   bus_if.SENT, cyc);
        end else begin
          e = exp_q.pop_front();
          check("sent_kind", e.is_sent, 1'b1);
          check("sent_val", bus_if.SENT, e.val);
          check("sent_hold", cyc - last_issue_cyc, HOLD);
          check("busy_fall", bus_if.BUSY, 1'b0);
        end
        last_sent_cyc = cyc;
      end
      if (prev_busy && !bus_if.BUSY && bus_if.SENT == 4'h0) begin
        checks++; errors++;
        $display("FAIL busy_early: got BUSY 0 without SENT required BUSY held (cycle %0d)", cyc);
      end
      prev_busy = bus_if.BUSY;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1;
    bus_if.EN = 1'b1;
    bus_if.REQ_STATUS = 8'h00;

    // Reset values and quiet idle.
    tick(3);
    check("rst_sync", bus_if.SYNC_DATA, 4'h0);
    check("rst_busy", bus_if.BUSY, 1'b0);
    check("rst_sent", bus_if.SENT, 4'h0);
    RST = 1'b0;
    tick(50);
    check("idle_sync", bus_if.SYNC_DATA, 4'h0);
    check("idle_busy", bus_if.BUSY, 1'b0);

    // Single change: requester 2 -> 11.
    bus_if.REQ_STATUS = 8'h30;
    push_issue(4'hB, cyc + 2, -1);
    push_sent(4'b0100);
    drain("single", 40);

    // Simultaneous change on all four from rr = 0.
    pulse_reset();
    bus_if.REQ_STATUS = 8'h55;
    push_issue(4'h1, cyc + 2, -1); push_sent(4'b0001);
    push_issue(4'h5, -1, 1);       push_sent(4'b0010);
    push_issue(4'h9, -1, 1);       push_sent(4'b0100);
    push_issue(4'hD, -1, 1);       push_sent(4'b1000);
    drain("all4", 100);

    // Requester 1: 00 -> 01, moves to 10 mid-hold, then re-sent.
    pulse_reset();
    bus_if.REQ_STATUS = 8'h04;
    push_issue(4'h5, cyc + 2, -1); push_sent(4'b0010);
    push_issue(4'h6, -1, 1);       push_sent(4'b0010);
    tick(5);
    bus_if.REQ_STATUS = 8'h08;
    drain("chg_hold", 60);

    // Requester 1: 10 -> 00, reverts to old shadow 10 mid-hold, still re-sent.
    bus_if.REQ_STATUS = 8'h00;
    push_issue(4'h4, cyc + 2, -1); push_sent(4'b0010);
    push_issue(4'h6, -1, 1);       push_sent(4'b0010);
    tick(5);
    bus_if.REQ_STATUS = 8'h08;
    drain("revert_hold", 60);

    // EN gating: requester 3 dirty but blocked, then released; EN drop mid-hold.
    bus_if.EN = 1'b0;
    bus_if.REQ_STATUS = 8'h88;
    tick(20);
    check("en_block_busy", bus_if.BUSY, 1'b0);
    check("en_block_sync", bus_if.SYNC_DATA, 4'h6);
    bus_if.EN = 1'b1;
    push_issue(4'hE, cyc + 2, -1); push_sent(4'b1000);
    tick(3);
    bus_if.EN = 1'b0;
    drain("en_gate", 40);
    bus_if.EN = 1'b1;
    tick(5);

    // Reset three cycles into a hold; all nonzero requesters re-sent after.
    bus_if.REQ_STATUS = 8'h8B;
    push_issue(4'h3, cyc + 2, -1);
    tick(4);
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid_sync", bus_if.SYNC_DATA, 4'h0);
    check("rst_mid_busy", bus_if.BUSY, 1'b0);
    check("rst_mid_sent", bus_if.SENT, 4'h0);
    check("rst_mid_q", exp_q.size(), 0);
    exp_q.delete();
    push_issue(4'h3, -1, -1); push_sent(4'b0001);
    push_issue(4'h6, -1, 1);  push_sent(4'b0010);
    push_issue(4'hE, -1, 1);  push_sent(4'b1000);
    tick(2);
    RST = 1'b0;
    drain("rst_resend", 100);

    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
